// File: rtl/irq_source_arbiter.sv
// Latches peripheral interrupt lines into pending bits and arbitrates them by fixed priority into one controller request.
// Define IRQ_EDGE_DETECT_EN for rising-edge pend capture; the default build uses level capture.
module irq_source_arbiter #(
  parameter  int N_SRC = 8,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_lines_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             irq_taken_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0] irq_active_o,
  output logic [N_SRC-1:0] irq_pending_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [N_SRC-1:0]   active_q, active_d;
  logic [N_SRC-1:0]   set_w;
  logic [N_SRC-1:0]   clr_w;
  logic [N_SRC-1:0]   cand_w;
  logic [ID_W-1:0]    sel_idx;
  logic [N_SRC-1:0]   sel_oh;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_SRC-1:0]   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= irq_lines_i;
  end

  assign set_w = irq_lines_i & ~prev_q;
`else
  assign set_w = irq_lines_i;
`endif

  // Set is OR'd in after the clear so a same-cycle re-assertion re-pends the source.
  assign clr_w     = (state_q == SERVICE && irq_ret_i) ? active_q : '0;
  assign pending_d = (pending_q & ~clr_w) | set_w;
  assign cand_w    = pending_q & irq_mask_i;

  always_comb begin
    sel_idx = '0;
    sel_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand_w[i]) begin
        sel_idx   = ID_W'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (|cand_w) begin
          state_d  = REQ;
          id_d     = sel_idx;
          active_d = sel_oh;
        end
      end
      REQ: begin
        if (irq_taken_i) state_d = SERVICE;
      end
      SERVICE: begin
        if (irq_ret_i) begin
          state_d  = IDLE;
          active_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      id_q      <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      id_q      <= id_d;
      active_q  <= active_d;
    end
  end

  assign irq_req_o     = (state_q == REQ);
  assign irq_id_o      = id_q;
  assign irq_active_o  = active_q;
  assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_irq_source_arbiter.sv
// Directed bench for irq_source_arbiter; expected request IDs are queued at stimulus time and checked when irq_req_o rises.
module tb_irq_source_arbiter;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] irq_lines_i;
  logic [7:0] irq_mask_i;
  logic       irq_taken_i;
  logic       irq_ret_i;
  logic       irq_req_o;
  logic [2:0] irq_id_o;
  logic [7:0] irq_active_o;
  logic [7:0] irq_pending_o;

  int total  = 0;
  int passed = 0;
  int exp_q[$];

  irq_source_arbiter #(.N_SRC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_lines_i(irq_lines_i), .irq_mask_i(irq_mask_i),
    .irq_taken_i(irq_taken_i), .irq_ret_i(irq_ret_i), .irq_req_o(irq_req_o),
    .irq_id_o(irq_id_o), .irq_active_o(irq_active_o), .irq_pending_o(irq_pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // One-cycle pulse on the given lines.
  task automatic pulse(input logic [7:0] v);
    irq_lines_i = v;
    tick();
    irq_lines_i = 8'h00;
  endtask

  // Wait up to maxc negedges for a request, then check it against the scoreboard.
  task automatic wait_req(input string tag, input int maxc);
    int id;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (irq_req_o) break;
    end
    chk({tag, "_req"}, irq_req_o, 1);
    chk({tag, "_sb"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      id = exp_q.pop_front();
      chk({tag, "_id"}, irq_id_o, id);
      chk({tag, "_active"}, irq_active_o, 32'(8'h01 << id));
    end
  endtask

  task automatic take();
    irq_taken_i = 1'b1;
    tick();
    irq_taken_i = 1'b0;
  endtask

  task automatic retire();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; irq_lines_i = 8'h00; irq_mask_i = 8'hFF; irq_taken_i = 1'b0; irq_ret_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("rst_req", irq_req_o, 0);
    chk("rst_id", irq_id_o, 0);
    chk("rst_active", irq_active_o, 0);
    chk("rst_pending", irq_pending_o, 0);

    // Single source: pending after one edge, request after the next.
    exp_q.push_back(3);
    pulse(8'h08);
    chk("t1_pend", irq_pending_o, 8'h08);
    chk("t1_noreq_yet", irq_req_o, 0);
    wait_req("t1", 1);
    take();
    chk("t1_taken_req", irq_req_o, 0);
    chk("t1_svc_id", irq_id_o, 3);
    chk("t1_svc_active", irq_active_o, 8'h08);
    retire();
    chk("t1_ret_pend", irq_pending_o, 8'h00);
    chk("t1_idle_active", irq_active_o, 8'h00);
    chk("t1_idle_id_kept", irq_id_o, 3);
    tick();
    chk("t1_idle_req", irq_req_o, 0);

    // Priority freeze: source 1 arrives while 5 is requested.
    exp_q.push_back(5);
    pulse(8'h20);
    wait_req("t2a", 1);
    exp_q.push_back(1);
    pulse(8'h02);
    chk("t2_frozen_req", irq_id_o, 5);
    chk("t2_pend", irq_pending_o, 8'h22);
    take();
    tick();
    chk("t2_frozen_svc", irq_id_o, 5);
    chk("t2_svc_req", irq_req_o, 0);
    retire();
    chk("t2_idle_req", irq_req_o, 0);
    chk("t2_idle_active", irq_active_o, 8'h00);
    chk("t2_idle_pend", irq_pending_o, 8'h02);
    wait_req("t2b", 1);
    take();
    retire();
    chk("t2_clear", irq_pending_o, 8'h00);

    // Masked source latches but is not requested until enabled.
    irq_mask_i = 8'hFB;
    pulse(8'h04);
    repeat (2) tick();
    chk("t3_pend", irq_pending_o, 8'h04);
    chk("t3_masked_req", irq_req_o, 0);
    exp_q.push_back(2);
    irq_mask_i = 8'hFF;
    wait_req("t3", 2);
    take();
    retire();
    chk("t3_clear", irq_pending_o, 8'h00);

    // Same-cycle re-pend of the serviced source.
    exp_q.push_back(4);
    pulse(8'h10);
    wait_req("t4a", 1);
    take();
    irq_lines_i = 8'h10;
    irq_ret_i   = 1'b1;
    tick();
    irq_lines_i = 8'h00;
    irq_ret_i   = 1'b0;
    chk("t4_repend", irq_pending_o, 8'h10);
    chk("t4_idle_req", irq_req_o, 0);
    chk("t4_idle_active", irq_active_o, 8'h00);
    exp_q.push_back(4);
    wait_req("t4b", 1);
    take();
    retire();
    chk("t4_clear", irq_pending_o, 8'h00);

    // Line 0 held high across return.
    exp_q.push_back(0);
    irq_lines_i = 8'h01;
    wait_req("t5a", 2);
    take();
    retire();
`ifdef IRQ_EDGE_DETECT_EN
    chk("t5_held_pend", irq_pending_o, 8'h00);
    repeat (3) tick();
    chk("t5_no_second_req", irq_req_o, 0);
    irq_lines_i = 8'h00;
`else
    chk("t5_held_pend", irq_pending_o, 8'h01);
    exp_q.push_back(0);
    wait_req("t5b", 1);
    irq_lines_i = 8'h00;
    take();
    retire();
`endif
    chk("t5_clear", irq_pending_o, 8'h00);

    // Reset in SERVICE drops everything; a stray return is ignored.
    exp_q.push_back(0);
    pulse(8'h81);
    wait_req("t6", 1);
    take();
    chk("t6_pend_pre", irq_pending_o, 8'h81);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_req", irq_req_o, 0);
    chk("t6_pend", irq_pending_o, 8'h00);
    chk("t6_active", irq_active_o, 8'h00);
    chk("t6_id", irq_id_o, 0);
    retire();
    repeat (2) tick();
    chk("t6_stray_req", irq_req_o, 0);
    chk("t6_stray_pend", irq_pending_o, 8'h00);
    chk("t6_stray_active", irq_active_o, 8'h00);

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
